// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC and pipeline-hold scheduler for the instruction-fetch front end.
// It picks the address the PC loads each cycle, the per-stage hold vector and the
// IF/ID bubble. It also parks a redirect that arrives while a fetch is outstanding,
// and flags an instruction memory that stays silent for too long.
// Optional feature macro: DELAY_SLOT_EN (when defined, a redirect taken in RUN keeps
// the instruction already fetched after the branch instead of flushing it).
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        imem_ready_i,
  output logic [31:0] next_addr_o,
  output logic [4:0]  stall_o,
  output logic        flush_ifid_o,
  output logic        imem_req_o,
  output logic        misalign_o,
  output logic        imem_timeout_o
);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

`ifdef DELAY_SLOT_EN
  localparam logic FLUSH_ON_BRANCH = 1'b0;
`else
  localparam logic FLUSH_ON_BRANCH = 1'b1;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [7:0]  r_wait_cnt;
  logic        r_misalign;
  logic        r_timeout;

  logic [4:0]  w_stall_vec;
  logic        w_any_stall;
  logic        w_capture;
  logic        w_clear_pend;
  logic        w_enter_wait;
  logic        w_accept;
  logic [31:0] w_accept_target;

  // Stage stall requests mapped to a hold vector, deepest requesting stage wins.
  always_comb begin
    w_stall_vec = 5'b00000;
    w_any_stall = 1'b1;
    if (stallreq_mem_i) begin
      w_stall_vec = 5'b01111;
    end else if (stallreq_ex_i) begin
      w_stall_vec = 5'b00111;
    end else if (stallreq_id_i) begin
      w_stall_vec = 5'b00011;
    end else begin
      w_stall_vec = 5'b00000;
      w_any_stall = 1'b0;
    end
  end

  // Next-state decode plus all combinational front-end controls.
  always_comb begin
    w_next_state    = r_state;
    next_addr_o     = pc_i;
    stall_o         = 5'b00000;
    flush_ifid_o    = 1'b0;
    imem_req_o      = 1'b0;
    w_capture       = 1'b0;
    w_clear_pend    = 1'b0;
    w_enter_wait    = 1'b0;
    w_accept        = 1'b0;
    w_accept_target = branch_target_i;
    case (r_state)
      ST_RESET: begin
        next_addr_o  = RESET_VECTOR;
        flush_ifid_o = 1'b1;
        w_next_state = ST_RUN;
      end
      ST_RUN: begin
        imem_req_o = 1'b1;
        if (w_any_stall) begin
          stall_o = w_stall_vec;
        end else if (!imem_ready_i) begin
          // Fetch not back yet: hold PC, bubble IF/ID, park any redirect.
          stall_o      = 5'b00001;
          flush_ifid_o = 1'b1;
          w_next_state = ST_MEM_WAIT;
          w_enter_wait = 1'b1;
          w_capture    = branch_flag_i;
        end else if (branch_flag_i) begin
          next_addr_o  = {branch_target_i[31:2], 2'b00};
          flush_ifid_o = FLUSH_ON_BRANCH;
          w_accept     = 1'b1;
        end else begin
          next_addr_o = pc_i + 32'd4;
        end
      end
      ST_MEM_WAIT: begin
        imem_req_o = 1'b1;
        if (w_any_stall) begin
          stall_o      = w_stall_vec | 5'b00001;
          flush_ifid_o = 1'b1;
        end else if (!imem_ready_i) begin
          stall_o      = 5'b00001;
          flush_ifid_o = 1'b1;
          w_capture    = branch_flag_i & ~r_pend_valid;
        end else if (r_pend_valid) begin
          // The parked redirect lands; the slot behind it is already a bubble.
          next_addr_o     = {r_pend_target[31:2], 2'b00};
          flush_ifid_o    = 1'b1;
          w_clear_pend    = 1'b1;
          w_accept        = 1'b1;
          w_accept_target = r_pend_target;
          w_next_state    = ST_RUN;
        end else if (branch_flag_i) begin
          next_addr_o  = {branch_target_i[31:2], 2'b00};
          flush_ifid_o = FLUSH_ON_BRANCH;
          w_accept     = 1'b1;
          w_next_state = ST_RUN;
        end else begin
          next_addr_o  = pc_i + 32'd4;
          w_next_state = ST_RUN;
        end
      end
      default: begin
        next_addr_o  = RESET_VECTOR;
        flush_ifid_o = 1'b1;
        w_next_state = ST_RESET;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Pending redirect captured during a fetch wait; the first target wins.
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_RESET)) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0000_0000;
    end else if (w_capture) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= branch_target_i;
    end else if (w_clear_pend) begin
      r_pend_valid  <= 1'b0;
    end
  end

  // Wait counter with a single timeout pulse, then saturation.
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_RESET) || w_enter_wait) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else if ((r_state == ST_MEM_WAIT) && (r_wait_cnt != TIMEOUT_CYCLES)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
      r_timeout  <= ((r_wait_cnt + 8'd1) == TIMEOUT_CYCLES);
    end else begin
      r_timeout  <= 1'b0;
    end
  end

  // One-cycle flag when an accepted redirect target was not word aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept & (w_accept_target[1:0] != 2'b00);
    end
  end

  assign misalign_o     = r_misalign;
  assign imem_timeout_o = r_timeout;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Next-PC and stall scheduler for the instruction-fetch front end. It sits beside the PC register and decides, every cycle, which address the PC loads and which pipeline registers hold or take a bubble. Decisions are based on stage stall requests, ID-stage branch redirects and the instruction-memory ready handshake. It also tracks redirects that arrive during a fetch wait, and watches for an instruction memory that never responds.

## Interface
- RESET_VECTOR, 32'h0000_0000, address loaded into the PC after reset.
- TIMEOUT_CYCLES, 255, number of MEM_WAIT cycles before imem_timeout_o pulses; range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_i  in  32  current PC-register value.
- stallreq_id_i  in  1  stall request from ID.
- stallreq_ex_i  in  1  stall request from EX.
- stallreq_mem_i  in  1  stall request from MEM.
- branch_flag_i  in  1  ID requests a redirect.
- branch_target_i  in  32  redirect address.
- imem_ready_i  in  1  instruction memory has returned the word for pc_i.
- next_addr_o  out  32  address the PC loads at the next edge.
- stall_o  out  5  hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB. 1 = hold.
- flush_ifid_o  out  1  IF/ID loads a bubble.
- imem_req_o  out  1  fetch request to instruction memory.
- misalign_o  out  1  registered 1-cycle pulse; the last accepted redirect target had nonzero bits [1:0].
- imem_timeout_o  out  1  registered 1-cycle pulse on wait-counter expiry.

## Operation
- The FSM has three states: RESET, RUN, MEM_WAIT.
- **RESET** (forced while rst=1, and held for the first cycle after rst falls):
  - next_addr_o=RESET_VECTOR, stall_o=5'b00000 (so the PC loads the vector), flush_ifid_o=1, imem_req_o=0.
  - Pending register cleared; wait counter cleared.
  - Goes to RUN.
- **RUN**: imem_req_o=1. Priority is highest first:
  - stallreq_mem_i: stall_o=5'b01111, next_addr_o=pc_i.
  - stallreq_ex_i: stall_o=5'b00111, next_addr_o=pc_i.
  - stallreq_id_i: stall_o=5'b00011, next_addr_o=pc_i.
  - imem_ready_i=0: stall_o=5'b00001, flush_ifid_o=1, next_addr_o=pc_i, go to MEM_WAIT. If branch_flag_i=1 in that cycle, capture the target into the pending register.
  - branch_flag_i=1: next_addr_o={branch_target_i[31:2],2'b00}, stall_o=0, flush_ifid_o per DELAY_SLOT_EN.
  - Otherwise: next_addr_o=pc_i+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), stall_o=0.
  - branch_flag_i is ignored whenever any stallreq is active, because ID re-presents it.
- **MEM_WAIT**: imem_req_o=1, stall_o=5'b00001, flush_ifid_o=1, next_addr_o=pc_i, wait counter increments each cycle.
  - stallreq_* are combined as in RUN (stall_o is the OR of both vectors); the FSM stays in MEM_WAIT.
  - On imem_ready_i=1 with a pending redirect: next_addr_o=pending target, flush_ifid_o=1, pending cleared, go to RUN.
  - On imem_ready_i=1 with no pending redirect: behave as RUN for that cycle, go to RUN.
  - A second branch_flag_i while pending is already valid is ignored; the first target wins.
- **Wait counter**: 8-bit.
  - Cleared on entry to MEM_WAIT and in RESET.
  - On reaching TIMEOUT_CYCLES, imem_timeout_o pulses once; the counter then saturates with no further pulses.
  - The FSM keeps waiting after the pulse.
- **misalign_o**: set for one cycle after a redirect is accepted with target[1:0]≠0; the address used is always aligned.
- **Reset mid-operation**: rst overrides all states and the pending register in the same edge.

## Timing
- next_addr_o, stall_o, flush_ifid_o and imem_req_o are combinational from state, the pending register and the inputs. There are no registered outputs except misalign_o and imem_timeout_o.
- Redirect latency: the target appears on next_addr_o in the same cycle branch_flag_i is sampled with no stall; the PC holds it after the next edge.
- A pending redirect reaches the PC at the edge following the imem_ready_i=1 cycle.
- Reset values: state=RESET, pending=0, counter=0, misalign_o=0, imem_timeout_o=0; combinational outputs take their RESET-state values.

## Configuration
- DELAY_SLOT_EN defined: a redirect accepted in RUN does not assert flush_ifid_o, so the instruction fetched after the branch executes. A pending redirect applied in MEM_WAIT still flushes, because that slot is already a bubble.
- DELAY_SLOT_EN undefined: every accepted redirect asserts flush_ifid_o for that cycle.

## Test plan
- Reset release with RESET_VECTOR=32'h0000_0100, imem_ready_i=1 -> first RUN cycle next_addr_o=32'h104 when pc_i=32'h100; stall_o=0.
- stallreq_ex_i and stallreq_id_i high together, pc_i=32'h20 -> stall_o=5'b00111, next_addr_o=32'h20; branch_flag_i in the same cycle has no effect.
- branch_flag_i=1, target=32'h0000_0402 -> next_addr_o=32'h400, misalign_o=1 one cycle later; flush_ifid_o=1 only when DELAY_SLOT_EN is undefined.
- imem_ready_i=0 for 3 cycles with branch to 32'h800 in the first cycle -> stall_o=5'b00001 throughout; ready cycle drives next_addr_o=32'h800 with flush_ifid_o=1.
- imem_ready_i held 0 with TIMEOUT_CYCLES=4 -> imem_timeout_o single pulse in the cycle after the 4th wait cycle, no repeat; rst then returns the FSM to RESET.
- pc_i=32'hFFFF_FFFC, no events -> next_addr_o=32'h0000_0000.
